// File: rtl/spread_qpsk_mapper_if.sv
// Bundle of the word-input handshake and the paced sample output of the
// spread-spectrum BPSK/QPSK mapper. The mapper takes the slave modport and
// the producer/consumer side takes the master modport.
interface spread_qpsk_mapper_if #(
    parameter int DATA_W   = 8,
    parameter int SAMPLE_W = 16
);
    logic [DATA_W-1:0]          i_data;
    logic                       i_mode;
    logic                       i_valid;
    logic                       o_ready;
    logic                       i_enable;
    logic signed [SAMPLE_W-1:0] o_i;
    logic signed [SAMPLE_W-1:0] o_q;
    logic                       o_valid;
    logic                       o_busy;

    modport master (
        output i_data, i_mode, i_valid, i_enable,
        input  o_ready, o_i, o_q, o_valid, o_busy
    );

    modport slave (
        input  i_data, i_mode, i_valid, i_enable,
        output o_ready, o_i, o_q, o_valid, o_busy
    );
endinterface

// File: rtl/spread_qpsk_mapper.sv
// Direct-sequence spread BPSK/QPSK mapper.
// Words are shifted out MSB first, one symbol (1 bit BPSK, 2 bits QPSK) per
// SPREAD chips, one chip every CHIP_DIV enabled clocks. Each chip is the data
// bit optionally XORed with a 7-bit PN sequence and mapped to +/-AMP.
// A one-word holding register allows gap-free back-to-back words.
module spread_qpsk_mapper #(
    parameter int          DATA_W   = 8,
    parameter int          SPREAD   = 24,
    parameter int          CHIP_DIV = 120,
    parameter int          SAMPLE_W = 16,
    parameter int          AMP      = 8192,
    parameter int          PN_EN    = 1,
    parameter logic [6:0]  PN_SEED  = 7'h7F
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    spread_qpsk_mapper_if.slave  bus
);

    localparam int TIMER_W = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
    localparam int CHIP_W  = (SPREAD > 1) ? $clog2(SPREAD) : 1;
    localparam int SYM_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [TIMER_W-1:0] TIMER_LAST    = TIMER_W'(CHIP_DIV - 1);
    localparam logic [CHIP_W-1:0]  CHIP_LAST     = CHIP_W'(SPREAD - 1);
    localparam logic [SYM_W-1:0]   SYM_LAST_BPSK = SYM_W'(DATA_W - 1);
    localparam logic [SYM_W-1:0]   SYM_LAST_QPSK = SYM_W'(DATA_W / 2 - 1);

    localparam logic signed [SAMPLE_W-1:0] POS_AMP = SAMPLE_W'(AMP);
    localparam logic signed [SAMPLE_W-1:0] NEG_AMP = SAMPLE_W'(-AMP);
    localparam logic                       PN_ON   = (PN_EN != 0);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t state_q;
    state_t state_d;

    // Active word being shifted out, and the one-deep holding slot.
    logic [DATA_W-1:0] act_data;
    logic              act_mode;
    logic [DATA_W-1:0] hold_data;
    logic              hold_mode;
    logic              hold_full;

    // Keeps o_ready low until the first clock edge after reset release.
    logic              ready_en;

    logic [TIMER_W-1:0] timer;
    logic [CHIP_W-1:0]  chip_cnt;
    logic [SYM_W-1:0]   sym_cnt;
    logic [6:0]         lfsr;

    // Last emitted samples, held between strobes.
    logic signed [SAMPLE_W-1:0] out_i;
    logic signed [SAMPLE_W-1:0] out_q;

    logic                       accept;
    logic                       tick;
    logic                       chip_wrap;
    logic                       word_end;
    logic [SYM_W-1:0]           sym_last;
    logic                       pn;
    logic                       chip_i;
    logic                       chip_q;
    logic signed [SAMPLE_W-1:0] map_i;
    logic signed [SAMPLE_W-1:0] map_q;

    assign accept    = bus.i_valid && bus.o_ready;
    assign tick      = (state_q == ST_RUN) && bus.i_enable && (timer == TIMER_LAST);
    assign chip_wrap = tick && (chip_cnt == CHIP_LAST);
    assign sym_last  = act_mode ? SYM_LAST_QPSK : SYM_LAST_BPSK;
    assign word_end  = chip_wrap && (sym_cnt == sym_last);

    // I takes the leading bit of the symbol, Q the next; both share one pn bit.
    assign pn     = PN_ON & lfsr[6];
    assign chip_i = act_data[DATA_W-1] ^ pn;
    assign chip_q = act_data[DATA_W-2] ^ pn;
    assign map_i  = chip_i ? NEG_AMP : POS_AMP;
    assign map_q  = act_mode ? (chip_q ? NEG_AMP : POS_AMP) : '0;

    // The strobe is combinational so the new sample appears in the very cycle
    // the timer reaches its last count; the registers hold it afterwards.
    assign bus.o_valid = tick;
    assign bus.o_i     = tick ? map_i : out_i;
    assign bus.o_q     = tick ? map_q : out_q;
    assign bus.o_busy  = (state_q == ST_RUN);
    assign bus.o_ready = ready_en && !hold_full;

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start on accept, stop at the end of a word unless another
    // word is waiting in holding or arrives in that same cycle.
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN:  if (word_end && !hold_full && !accept) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Ready qualifier: rises on the first edge out of reset.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Chip timer: runs only in RUN, freezes while downstream is not enabled.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            timer <= '0;
        end else if (state_q != ST_RUN) begin
            timer <= '0;
        end else if (bus.i_enable) begin
            timer <= (timer == TIMER_LAST) ? '0 : timer + 1'b1;
        end
    end

    // Chip and symbol counters, stepped once per emitted chip.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            chip_cnt <= '0;
            sym_cnt  <= '0;
        end else if (state_q != ST_RUN) begin
            chip_cnt <= '0;
            sym_cnt  <= '0;
        end else if (tick) begin
            if (chip_cnt == CHIP_LAST) begin
                chip_cnt <= '0;
                sym_cnt  <= (sym_cnt == sym_last) ? '0 : sym_cnt + 1'b1;
            end else begin
                chip_cnt <= chip_cnt + 1'b1;
            end
        end
    end

    // PN generator: free-running across words, reseeded only by reset.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            lfsr <= PN_SEED;
        end else if (tick) begin
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        end
    end

    // Word storage: direct load when idle, holding-to-active reload at the
    // last chip of a word, symbol shift at every other symbol boundary.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            act_data  <= '0;
            act_mode  <= 1'b0;
            hold_data <= '0;
            hold_mode <= 1'b0;
            hold_full <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (accept) begin
                act_data <= bus.i_data;
                act_mode <= bus.i_mode;
            end
        end else if (word_end) begin
            if (hold_full) begin
                act_data  <= hold_data;
                act_mode  <= hold_mode;
                hold_full <= 1'b0;
            end else if (accept) begin
                act_data <= bus.i_data;
                act_mode <= bus.i_mode;
            end
        end else begin
            if (chip_wrap) begin
                act_data <= act_mode ? (act_data << 2) : (act_data << 1);
            end
            if (accept) begin
                hold_data <= bus.i_data;
                hold_mode <= bus.i_mode;
                hold_full <= 1'b1;
            end
        end
    end

    // Sample hold registers, loaded with each emitted chip.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            out_i <= '0;
            out_q <= '0;
        end else if (tick) begin
            out_i <= map_i;
            out_q <= map_q;
        end
    end

endmodule
